// File: rtl/linked_list_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : linked_list_arbiter_pkg
// Description : Shared defaults, derived widths and the op-class enum for the
//               linked-list arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package linked_list_arbiter_pkg;

  localparam int DEF_NUM_LISTS = 2;
  localparam int DEF_NUM_ELEMS = 4;
  localparam int DEF_CNT_WIDTH = $clog2(DEF_NUM_ELEMS) + 1;
  localparam int DEF_PTR_WIDTH = (DEF_NUM_LISTS > 1) ? $clog2(DEF_NUM_LISTS) : 1;

  // Operation class; also records which class was granted most recently.
  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_class_e;

endpackage : linked_list_arbiter_pkg
`default_nettype wire

// File: rtl/linked_list_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin one-hot picker. The search begins
//               at ptr_i, which the owner keeps one above its last grant,
//               and wraps from N-1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  // Scan N positions starting at the pointer; the first requester wins.
  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule : rr_picker
`default_nettype wire

// File: rtl/linked_list_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : linked_list_arbiter
// Description : Push/pop arbiter in front of a shared-node linked list. Keeps
//               shadow occupancy counters, alternates between push and pop
//               classes, round-robins within a class, and flags any
//               disagreement between its shadow state and the list's flags.
// Revision    : 1.0 - initial release
// ============================================================================
module linked_list_arbiter
  import linked_list_arbiter_pkg::*;
#(
  parameter int NUM_LISTS = DEF_NUM_LISTS,
  parameter int NUM_ELEMS = DEF_NUM_ELEMS,
  parameter int CNT_WIDTH = $clog2(NUM_ELEMS) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LISTS-1:0] push_req_i,
  input  logic [NUM_LISTS-1:0] pop_req_i,
  output logic [NUM_LISTS-1:0] push_o,
  output logic [NUM_LISTS-1:0] pop_o,
  input  logic                 ll_full_i,
  input  logic [NUM_LISTS-1:0] ll_empty_i,
  output logic                 full_o,
  output logic [NUM_LISTS-1:0] empty_o,
  output logic                 sync_err_o
);

  localparam int PTR_WIDTH = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1;
  localparam logic [CNT_WIDTH-1:0] MAX_TOTAL = CNT_WIDTH'(NUM_ELEMS);

  // Registered state
  logic [NUM_LISTS-1:0] push_q, push_d;
  logic [NUM_LISTS-1:0] pop_q,  pop_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_LISTS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_LISTS];
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [PTR_WIDTH-1:0] push_ptr_q, push_ptr_d;
  logic [PTR_WIDTH-1:0] pop_ptr_q,  pop_ptr_d;
  op_class_e            last_q, last_d;
  logic                 start_q;
  logic                 sync_err_q, sync_err_d;

  // Combinational helpers
  logic [NUM_LISTS-1:0] push_elig, pop_elig;
  logic [NUM_LISTS-1:0] push_gnt,  pop_gnt;
  logic [PTR_WIDTH-1:0] push_idx,  pop_idx;
  logic                 push_any,  pop_any;
  logic                 use_push,  use_pop;
  logic                 idle_prev;

  // Eligibility: room/occupancy available and not granted to this list last cycle.
  always_comb begin
    push_elig = '0;
    pop_elig  = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      push_elig[i] = push_req_i[i] && !push_q[i] && (total_q < MAX_TOTAL);
      pop_elig[i]  = pop_req_i[i]  && !pop_q[i]  && (cnt_q[i] != '0);
    end
  end

  rr_picker #(.N(NUM_LISTS), .PW(PTR_WIDTH)) u_push_pick (
    .req_i (push_elig),
    .ptr_i (push_ptr_q),
    .gnt_o (push_gnt),
    .idx_o (push_idx),
    .any_o (push_any)
  );

  rr_picker #(.N(NUM_LISTS), .PW(PTR_WIDTH)) u_pop_pick (
    .req_i (pop_elig),
    .ptr_i (pop_ptr_q),
    .gnt_o (pop_gnt),
    .idx_o (pop_idx),
    .any_o (pop_any)
  );

  // Class select: on contention the class not granted most recently wins.
  always_comb begin
    use_push = push_any && (!pop_any || (last_q == OP_POP));
    use_pop  = pop_any && !use_push;
  end

  // Next-state: register the grant and move the shadow counters on the same edge.
  always_comb begin
    push_d     = '0;
    pop_d      = '0;
    cnt_d      = cnt_q;
    total_d    = total_q;
    push_ptr_d = push_ptr_q;
    pop_ptr_d  = pop_ptr_q;
    last_d     = last_q;
    if (start_q) begin
      if (use_push) begin
        push_d            = push_gnt;
        cnt_d[push_idx]   = cnt_q[push_idx] + 1'b1;
        total_d           = total_q + 1'b1;
        push_ptr_d        = PTR_WIDTH'((int'(push_idx) + 1) % NUM_LISTS);
        last_d            = OP_PUSH;
      end else if (use_pop) begin
        pop_d             = pop_gnt;
        cnt_d[pop_idx]    = cnt_q[pop_idx] - 1'b1;
        total_d           = total_q - 1'b1;
        pop_ptr_d         = PTR_WIDTH'((int'(pop_idx) + 1) % NUM_LISTS);
        last_d            = OP_POP;
      end
    end
  end

  // Consistency check: only when no grant was outstanding in the cycle just
  // ending, because the list's flags trail the shadow by one cycle otherwise.
  always_comb begin
    idle_prev  = (push_q == '0) && (pop_q == '0);
    sync_err_d = sync_err_q;
    if (idle_prev && ((ll_full_i != full_o) || (ll_empty_i != empty_o))) begin
      sync_err_d = 1'b1;
    end
  end

  // State register; start_q holds off grants until the second edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q     <= '0;
      pop_q      <= '0;
      for (int i = 0; i < NUM_LISTS; i++) cnt_q[i] <= '0;
      total_q    <= '0;
      push_ptr_q <= '0;
      pop_ptr_q  <= '0;
      last_q     <= OP_POP;
      start_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      push_q     <= push_d;
      pop_q      <= pop_d;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      push_ptr_q <= push_ptr_d;
      pop_ptr_q  <= pop_ptr_d;
      last_q     <= last_d;
      start_q    <= 1'b1;
      sync_err_q <= sync_err_d;
    end
  end

  // Output flags derived from the shadow counters.
  always_comb begin
    full_o = (total_q == MAX_TOTAL);
    for (int i = 0; i < NUM_LISTS; i++) empty_o[i] = (cnt_q[i] == '0);
  end

  assign push_o     = push_q;
  assign pop_o      = pop_q;
  assign sync_err_o = sync_err_q;

endmodule : linked_list_arbiter
`default_nettype wire

// File: doc/linked_list_arbiter.md
LINKED_LIST_ARBITER -- requirements
Module: linked_list_arbiter

Interface
REQ-001 Parameter NUM_LISTS, default 2: number of lists served; SHALL equal the downstream linked-list instance's NUM_LISTS.
REQ-002 Parameter NUM_ELEMS, default 4: shared node count; SHALL equal the downstream NUM_ELEMS.
REQ-003 Parameter CNT_WIDTH, default $clog2(NUM_ELEMS)+1: width of all occupancy counters.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 push_req  input  NUM_LISTS  bit i requests an append to list i; held until the matching push bit is seen.
REQ-007 pop_req  input  NUM_LISTS  bit i requests a head removal from list i; held until the matching pop bit is seen.
REQ-008 push  output  NUM_LISTS  registered, zero or one-hot; drives the linked-list push input and acts as acknowledge.
REQ-009 pop  output  NUM_LISTS  registered, zero or one-hot; drives the linked-list pop input and acts as acknowledge.
REQ-010 ll_full  input  1  full flag from the linked list.
REQ-011 ll_empty  input  NUM_LISTS  per-list empty flags from the linked list.
REQ-012 full  output  1  shadow full: shadow total == NUM_ELEMS.
REQ-013 empty  output  NUM_LISTS  shadow empty: bit i set when shadow count i == 0.
REQ-014 sync_err  output  1  sticky flag: shadow state disagreed with the linked-list flags.

Function
REQ-015 At most one bit across {push, pop} SHALL be set in any cycle; push and pop never coexist.
REQ-016 Eligibility: push_req[i] is eligible iff shadow total < NUM_ELEMS and push was not asserted for list i last cycle; pop_req[i] is eligible iff shadow count i > 0 and pop was not asserted for list i last cycle.
REQ-017 Class selection: when both classes have an eligible request, the class not granted most recently SHALL win; otherwise the only class with an eligible request wins.
REQ-018 Within a class, the grant SHALL be round-robin: search starts at the list index one above the last grant of that class, wrapping from NUM_LISTS-1 to 0.
REQ-019 Grant latency: a request eligible at edge t SHALL appear on push or pop during cycle t+1, for exactly one cycle.
REQ-020 Shadow counts SHALL update on the same edge that registers the grant: +1 for push, -1 for pop, on both the list counter and the total.
REQ-021 Counters SHALL never wrap: pushing at total NUM_ELEMS and popping at count 0 are prevented by REQ-016.
REQ-022 Starvation bound: with requests held, each eligible request SHALL be granted within 2*NUM_LISTS cycles.
REQ-023 Check: in any cycle where push and pop were both zero on the previous cycle, sync_err SHALL set if ll_full != full or ll_empty != empty.
REQ-024 sync_err SHALL stay set until reset.
REQ-025 No requests: push and pop are zero and all state holds.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear push, pop, all shadow counts, and sync_err. full SHALL read 0, empty SHALL read all ones, both round-robin pointers SHALL return to list 0, and class priority SHALL return to push.
REQ-027 Reset mid-operation SHALL drop any in-flight grant with no acknowledge. Requesters SHALL re-present their requests after reset.
REQ-028 The first grant after deassertion SHALL occur no earlier than the second posedge.

Structure
REQ-029 A shared package SHALL hold NUM_LISTS/NUM_ELEMS defaults, the derived CNT_WIDTH/PTR_WIDTH constants, and the op-class enum {OP_PUSH, OP_POP}.
REQ-030 One sub-module, rr_picker, SHALL exist: a parameterised round-robin one-hot picker taking a request vector and a last-grant pointer. It SHALL be instantiated once per class.
REQ-031 Shadow counters, class priority, and the consistency checker SHALL live in the top module.

Verification
REQ-032 Reset: drive rst_n low mid-grant -> push=pop=0 asynchronously, empty=2'b11, full=0, sync_err=0.
REQ-033 Fill: push_req=2'b11 held with pop_req=0 -> grants alternate push=01,10,01,10. full=1 after the 4th grant, and no further push follows.
REQ-034 Empty guard: pop_req=2'b01 with count0=0 -> pop stays 0. After one push to list 0, pop=01 exactly once, then empty[0]=1.
REQ-035 Mixed: push_req=01 and pop_req=10 both eligible and held -> grant classes alternate push/pop each cycle and never appear together.
REQ-036 Back-to-back: a held push_req for the same list -> grant at most every other cycle per REQ-016.
REQ-037 Checker: connect a real linked_list instance, run 1000 random cycles -> sync_err stays 0. Force ll_empty[1] flipped in an idle cycle -> sync_err=1 and stays set.
